// File: rtl/uart_pkg.sv
// Shared UART definitions: default frame width, state encodings and parity helper.
// Used by both the transmit sequencer and the receiver.
package uart_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP1  = 3'd4;
  localparam logic [2:0] S_STOP2  = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE   = S_IDLE,
    ST_START  = S_START,
    ST_DATA   = S_DATA,
    ST_PARITY = S_PARITY,
    ST_STOP1  = S_STOP1,
    ST_STOP2  = S_STOP2
  } tx_state_e;

  // Data is zero-extended to the widest legal frame, so padding never flips parity.
  function automatic logic frame_parity(input logic [8:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_sequencer.sv
// UART transmit sequencer: frames a parallel word as start/data/parity/stop bits,
// advancing one bit per baud tick, with back-to-back frame support.
module uart_tx_sequencer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick,
  input  logic                  data_valid,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic                  stop2,
  output logic                  data_ack,
  output logic                  tx_out,
  output logic                  busy
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  tx_state_e             state_reg;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [CW-1:0]         count_reg;
  logic                  par_en_reg;
  logic                  stop2_reg;
  logic                  parity_reg;
  logic                  final_stop;
  logic                  accept;

  // A new word may start from idle or on the tick that ends the last stop bit.
  assign final_stop = (state_reg == ST_STOP2) || ((state_reg == ST_STOP1) && !stop2_reg);
  assign accept     = tick && data_valid && ((state_reg == ST_IDLE) || final_stop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      shift_reg  <= '0;
      count_reg  <= '0;
      par_en_reg <= 1'b0;
      stop2_reg  <= 1'b0;
      parity_reg <= 1'b0;
      tx_out     <= 1'b1;
      busy       <= 1'b0;
      data_ack   <= 1'b0;
    end else begin
      data_ack <= 1'b0;
      if (accept) begin
        state_reg  <= ST_START;
        shift_reg  <= p_data;
        count_reg  <= '0;
        par_en_reg <= par_en;
        stop2_reg  <= stop2;
        parity_reg <= frame_parity(9'(p_data), par_typ);
        tx_out     <= 1'b0;
        busy       <= 1'b1;
        data_ack   <= 1'b1;
      end else begin
        case (state_reg)
          ST_IDLE: begin
          end
          ST_START: if (tick) begin
            state_reg <= ST_DATA;
            tx_out    <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
            count_reg <= '0;
          end
          ST_DATA: if (tick) begin
            if (count_reg == LAST_BIT) begin
              if (par_en_reg) begin
                state_reg <= ST_PARITY;
                tx_out    <= parity_reg;
              end else begin
                state_reg <= ST_STOP1;
                tx_out    <= 1'b1;
              end
            end else begin
              tx_out    <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
              count_reg <= count_reg + CW'(1);
            end
          end
          ST_PARITY: if (tick) begin
            state_reg <= ST_STOP1;
            tx_out    <= 1'b1;
          end
          ST_STOP1, ST_STOP2: if (tick) begin
            if ((state_reg == ST_STOP1) && stop2_reg) begin
              state_reg <= ST_STOP2;
              tx_out    <= 1'b1;
            end else begin
              state_reg <= ST_IDLE;
              tx_out    <= 1'b1;
              busy      <= 1'b0;
            end
          end
          default: begin
            state_reg <= ST_IDLE;
            tx_out    <= 1'b1;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Self-checking bench: a frame-level reference model feeds a per-tick scoreboard,
// plus directed frame captures for the reference waveforms.
module tb_uart_tx_sequencer;

  typedef struct packed {
    logic tx;
    logic busy;
    logic ack;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       data_valid = 1'b0;
  logic [7:0] p_data = '0;
  logic       par_en = 1'b0;
  logic       par_typ = 1'b0;
  logic       stop2 = 1'b0;
  logic       data_ack, tx_out, busy;

  logic       dv5 = 1'b0;
  logic [4:0] pd5 = '0;
  logic       pe5 = 1'b0;
  logic       pt5 = 1'b0;
  logic       s25 = 1'b0;
  logic       ack5, tx5, busy5;

  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];
  logic last_tx = 1'b1;
  logic last_busy = 1'b0;
  int   obs[16];
  int   bt;
  int   nt;

  int seq031[11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
  int seq032[12] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 1, 1};
  int seq036[8]  = '{0, 1, 0, 1, 0, 1, 1, 1};

  always #5 clk = ~clk;

  uart_tx_sequencer #(.DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .data_valid(data_valid), .p_data(p_data),
    .par_en(par_en), .par_typ(par_typ), .stop2(stop2),
    .data_ack(data_ack), .tx_out(tx_out), .busy(busy)
  );

  uart_tx_sequencer #(.DATA_WIDTH(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .data_valid(dv5), .p_data(pd5),
    .par_en(pe5), .par_typ(pt5), .stop2(s25),
    .data_ack(ack5), .tx_out(tx5), .busy(busy5)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Baud ticks: one cycle wide, 2..4 cycles apart.
  initial begin
    int gap;
    gap = 2;
    forever begin
      @(negedge clk);
      if (gap == 0) begin
        tick = 1'b1;
        gap  = $urandom_range(1, 3);
      end else begin
        tick = 1'b0;
        gap--;
      end
    end
  end

  // Reference model: a frame is a list of line levels, one per tick.
  initial begin
    int   fq[$];
    exp_t e;
    int   d;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        fq.delete();
      end else if (tick) begin
        if (fq.size() == 0) begin
          if (data_valid) begin
            d = int'(p_data);
            fq.push_back(0);
            for (int b = 0; b < 8; b++) fq.push_back((d >> b) & 1);
            if (par_en) fq.push_back(($countones(p_data) % 2) ^ int'(par_typ));
            fq.push_back(1);
            if (stop2) fq.push_back(1);
            $display("accept data=%02h par_en=%0d par_typ=%0d stop2=%0d len=%0d",
                     p_data, par_en, par_typ, stop2, fq.size());
            e.tx   = fq.pop_front()[0];
            e.busy = 1'b1;
            e.ack  = 1'b1;
          end else begin
            e = '{tx: 1'b1, busy: 1'b0, ack: 1'b0};
          end
        end else begin
          e.tx   = fq.pop_front()[0];
          e.busy = 1'b1;
          e.ack  = 1'b0;
        end
        exp_q.push_back(e);
      end
    end
  end

  // Monitor: after every tick edge pop one expectation; between ticks outputs hold.
  initial begin
    logic t, r;
    exp_t e;
    forever begin
      @(posedge clk);
      t = tick;
      r = rst_n;
      @(negedge clk);
      if (!r) begin
        chk("rst_tx", tx_out, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ack", data_ack, 0);
        last_tx   = 1'b1;
        last_busy = 1'b0;
      end else if (t) begin
        chk("sb_depth", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("tick_tx", tx_out, e.tx);
          chk("tick_busy", busy, e.busy);
          chk("tick_ack", data_ack, e.ack);
          last_tx   = e.tx;
          last_busy = e.busy;
        end
      end else begin
        chk("notick_ack", data_ack, 0);
        chk("hold_tx", tx_out, last_tx);
        chk("hold_busy", busy, last_busy);
      end
    end
  end

  task automatic wait_ack(input bit sel, input string name, output int ticks);
    ticks = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      if (tick) ticks++;
      @(negedge clk);
      if ((sel ? ack5 : data_ack) === 1'b1) return;
    end
    chk({name, "_ack_timeout"}, 0, 1);
  endtask

  // Called at the ack edge: records the line for n ticks plus one trailing tick.
  task automatic capture(input bit sel, input int n);
    obs[0] = int'(sel ? tx5 : tx_out);
    bt     = int'(sel ? busy5 : busy);
    for (int i = 1; i <= n; i++) begin
      do @(posedge clk); while (!tick);
      @(negedge clk);
      if (i < n) obs[i] = int'(sel ? tx5 : tx_out);
      bt += int'(sel ? busy5 : busy);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_tx", tx_out, 1);
    chk("reset_busy", busy, 0);
    chk("reset_ack", data_ack, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Five-bit frame with even parity on the narrow instance.
    pd5 = 5'h15; pe5 = 1'b1; pt5 = 1'b0; s25 = 1'b0; dv5 = 1'b1;
    wait_ack(1'b1, "w5", nt);
    dv5 = 1'b0; pe5 = 1'b0;
    capture(1'b1, 8);
    for (int i = 0; i < 8; i++) chk($sformatf("w5_bit%0d", i), obs[i], seq036[i]);
    chk("w5_busy_ticks", bt, 8);

    // 0xA5 even parity, one stop; config scrambled mid-frame.
    p_data = 8'hA5; par_en = 1'b1; par_typ = 1'b0; stop2 = 1'b0; data_valid = 1'b1;
    wait_ack(1'b0, "a5_even", nt);
    data_valid = 1'b0; p_data = 8'h00; par_en = 1'b0; stop2 = 1'b1;
    capture(1'b0, 11);
    for (int i = 0; i < 11; i++) chk($sformatf("a5_even_bit%0d", i), obs[i], seq031[i]);
    chk("a5_even_busy_ticks", bt, 11);

    // 0xA5 odd parity, two stops.
    p_data = 8'hA5; par_en = 1'b1; par_typ = 1'b1; stop2 = 1'b1; data_valid = 1'b1;
    wait_ack(1'b0, "a5_odd", nt);
    data_valid = 1'b0; par_en = 1'b0; stop2 = 1'b0;
    capture(1'b0, 12);
    for (int i = 0; i < 12; i++) chk($sformatf("a5_odd_bit%0d", i), obs[i], seq032[i]);
    chk("a5_odd_busy_ticks", bt, 12);

    // Back-to-back frames: acks are one 10-tick frame apart.
    p_data = 8'h3C; par_en = 1'b0; stop2 = 1'b0; data_valid = 1'b1;
    wait_ack(1'b0, "b2b_first", nt);
    p_data = 8'hC3;
    wait_ack(1'b0, "b2b_second", nt);
    chk("b2b_ack_spacing", nt, 10);
    data_valid = 1'b0;
    repeat (60) @(negedge clk);

    // Reset while data bit 4 is on the line.
    p_data = 8'h5A; par_en = 1'b1; par_typ = 1'b0; stop2 = 1'b0; data_valid = 1'b1;
    wait_ack(1'b0, "rst_frame", nt);
    data_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      do @(posedge clk); while (!tick);
    end
    @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_tx", tx_out, 1);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_ack", data_ack, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("post_rst_line", tx_out, 1);
    chk("post_rst_busy", busy, 0);

    // Random traffic: inputs change every cycle, only acceptance-time values count.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      p_data     = 8'($urandom);
      par_en     = 1'($urandom);
      par_typ    = 1'($urandom);
      stop2      = 1'($urandom);
      data_valid = ($urandom_range(0, 3) != 0);
    end
    data_valid = 1'b0;
    repeat (80) @(negedge clk);
    chk("drain_busy", busy, 0);
    chk("drain_sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
